// File: rtl/bram_fetch_pkg.sv
// Shared types and defaults for the block-RAM line fetcher.
// Holds the fetch FSM state encoding and the default return-buffer depth.
// No logic; imported by the fetcher top.
package bram_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam int FIFO_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with occupancy count and synchronous flush.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: no internal guard beyond the full check; the caller keeps push off a full FIFO unless it pops too.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  cnt;

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (cnt == CNT_W'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;

endmodule

// File: rtl/bram_line_fetcher.sv
// Streams a run of consecutive RAM words from a 1-cycle registered RAM port into a valid/ready consumer.
// Latency: start -> first out_valid is 3 cycles; sustains 1 word/clock with out_ready held high.
// Backpressure: reads are issued only when buffer occupancy plus the in-flight word leaves room, so nothing is dropped.
module bram_line_fetcher
  import bram_fetch_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   line_len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rd_en,
  input  logic [DATA_W-1:0] ram_q,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state, state_next;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [ADDR_W:0]   remaining;
  logic              inflight;
  logic              zero_done_q;

  logic              pop;
  logic              issue;
  logic              accept_start;
  logic              last_xfer;
  logic [CNT_W:0]    occ_next;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;

  assign pop          = out_valid & out_ready;
  assign accept_start = (state == IDLE) & start & ~abort;

  // Occupancy after this cycle's pop and the landing in-flight word must leave room for one more read.
  assign occ_next = {1'b0, fifo_count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
  assign issue    = (state == FETCH) & (remaining != '0) & ~abort &
                    (occ_next < (CNT_W+1)'(FIFO_DEPTH));

  // Last word leaves in DRAIN when nothing else is buffered or in flight.
  assign last_xfer = (state == DRAIN) & pop & ~inflight &
                     (fifo_count == CNT_W'(1)) & ~abort;

  // Head-of-line guard: a push into a full buffer is only taken alongside a pop.
  assign fifo_push = inflight & ~abort & (~fifo_full | pop);

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (abort),
    .push      (fifo_push),
    .push_data (ram_q),
    .pop       (pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Next-state selection; abort always returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept_start && line_len != '0) state_next = FETCH;
      FETCH:   if (issue && remaining == (ADDR_W+1)'(1)) state_next = DRAIN;
      DRAIN:   if (last_xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Address/remaining counters, in-flight flag and the held RAM address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr        <= '0;
      remaining   <= '0;
      inflight    <= 1'b0;
      ram_addr_q  <= '0;
      zero_done_q <= 1'b0;
    end else if (abort) begin
      addr        <= '0;
      remaining   <= '0;
      inflight    <= 1'b0;
      zero_done_q <= 1'b0;
    end else begin
      inflight    <= issue;
      zero_done_q <= accept_start & (line_len == '0);
      if (accept_start) begin
        addr      <= base_addr;
        remaining <= line_len;
      end else if (issue) begin
        addr       <= addr + 1'b1;
        remaining  <= remaining - 1'b1;
        ram_addr_q <= addr;
      end
    end
  end

  assign ram_rd_en = issue;
  assign ram_addr  = issue ? addr : ram_addr_q;
  assign busy      = (state != IDLE);
  assign done      = zero_done_q | last_xfer;
  assign out_valid = ~fifo_empty;

endmodule
